// File: rtl/iir_coeff_bank_pkg.sv
// Shared definitions for the IIR coefficient bank: select encoding, FSM states
// and the reset-time coefficient table.
package iir_coeff_bank_pkg;

    localparam int unsigned SEL_W  = 3;
    localparam int unsigned N_COEF = 5;

    localparam logic [SEL_W-1:0] SEL_B0 = 3'd0;
    localparam logic [SEL_W-1:0] SEL_B1 = 3'd1;
    localparam logic [SEL_W-1:0] SEL_B2 = 3'd2;
    localparam logic [SEL_W-1:0] SEL_A1 = 3'd3;
    localparam logic [SEL_W-1:0] SEL_A2 = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_COPY  = 2'd2
    } state_t;

    // Q2.13 default cascade at 16 bits; stages past the table are unity pass-through.
    function automatic logic [15:0] def_coef(input int unsigned stage, input logic [SEL_W-1:0] sel);
        logic [15:0] row [N_COEF];
        case (stage)
            0:       row = '{16'h0FF8, 16'h1C9D, 16'h0FF8, 16'h0B1A, 16'h175D};
            1:       row = '{16'h0FF8, 16'hE363, 16'h0FF8, 16'hF4E6, 16'h175D};
            2:       row = '{16'h0FF8, 16'hEB7C, 16'h0FF8, 16'hE675, 16'h1C39};
            3:       row = '{16'h0FF8, 16'h1484, 16'h0FF8, 16'h198B, 16'h1C39};
            4:       row = '{16'h0FF8, 16'h120F, 16'h0FF8, 16'h1ED8, 16'h1F1B};
            5:       row = '{16'h0FF8, 16'hEDF1, 16'h0FF8, 16'hE128, 16'h1F1B};
            default: row = '{16'h2000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        endcase
        if (sel > SEL_A2) begin
            return 16'h0000;
        end
        return row[sel];
    endfunction

endpackage

// File: rtl/iir_coeff_ram2.sv
// Dual-bank coefficient register array: shadow write port, shadow<-active copy
// port and a registered active-bank read port.
module iir_coeff_ram2
    import iir_coeff_bank_pkg::*;
#(
    parameter int unsigned COEF_W   = 16,
    parameter int unsigned N_STAGES = 6,
    parameter int unsigned IDX_W    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bank_sel,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_stage,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [COEF_W-1:0] wr_data,
    input  logic              cp_en,
    input  logic [IDX_W-1:0]  cp_stage,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_stage,
    output logic [COEF_W-1:0] b0,
    output logic [COEF_W-1:0] b1,
    output logic [COEF_W-1:0] b2,
    output logic [COEF_W-1:0] a1,
    output logic [COEF_W-1:0] a2
);

    logic [COEF_W-1:0] mem [2][N_STAGES][N_COEF];

    function automatic logic [COEF_W-1:0] def_w(input int unsigned stage, input logic [SEL_W-1:0] sel);
        return COEF_W'($signed(def_coef(stage, sel)));
    endfunction

    // Storage; write and copy are mutually exclusive by construction in the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned s = 0; s < N_STAGES; s++) begin
                    for (int unsigned c = 0; c < N_COEF; c++) begin
                        mem[b][s][c] <= def_w(s, SEL_W'(c));
                    end
                end
            end
        end else begin
            if (wr_en) begin
                mem[~bank_sel][wr_stage][wr_sel] <= wr_data;
            end
            if (cp_en) begin
                for (int unsigned c = 0; c < N_COEF; c++) begin
                    mem[~bank_sel][cp_stage][c] <= mem[bank_sel][cp_stage][c];
                end
            end
        end
    end

    // Registered read of the active bank; holds when no read is requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b0 <= def_w(0, SEL_B0);
            b1 <= def_w(0, SEL_B1);
            b2 <= def_w(0, SEL_B2);
            a1 <= def_w(0, SEL_A1);
            a2 <= def_w(0, SEL_A2);
        end else if (rd_en) begin
            b0 <= mem[bank_sel][rd_stage][SEL_B0];
            b1 <= mem[bank_sel][rd_stage][SEL_B1];
            b2 <= mem[bank_sel][rd_stage][SEL_B2];
            a1 <= mem[bank_sel][rd_stage][SEL_A1];
            a2 <= mem[bank_sel][rd_stage][SEL_A2];
        end
    end

endmodule

// File: rtl/iir_coeff_bank.sv
// Double-buffered SOS coefficient bank: edits go to the shadow bank and are
// published atomically on a frame boundary, then mirrored back into the shadow.
module iir_coeff_bank
    import iir_coeff_bank_pkg::*;
#(
    parameter int unsigned COEF_W   = 16,
    parameter int unsigned N_STAGES = 6,
    parameter int unsigned IDX_W    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [IDX_W-1:0]  load_stage,
    input  logic [2:0]        load_sel,
    input  logic [COEF_W-1:0] load_data,
    input  logic              commit_req,
    input  logic              frame_boundary,
    output logic              commit_ack,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_stage,
    output logic [COEF_W-1:0] b0,
    output logic [COEF_W-1:0] b1,
    output logic [COEF_W-1:0] b2,
    output logic [COEF_W-1:0] a1,
    output logic [COEF_W-1:0] a2,
    output logic              rd_dvalid,
    output logic              err_idx,
    output logic              busy
);

    localparam int unsigned IW1   = IDX_W + 1;
    localparam int unsigned CNT_W = $clog2(N_STAGES + 1);

    state_t             state;
    state_t             next_state;
    logic               bank_sel;
    logic [CNT_W-1:0]   cnt;

    logic               swap_c;
    logic               cp_en_c;
    logic               done_c;
    logic               wr_hs_c;
    logic               wr_bad_c;
    logic               wr_en_c;
    logic               rd_bad_c;
    logic [IDX_W-1:0]   rd_idx_c;

    // Handshake and index qualification.
    always_comb begin
        wr_hs_c  = load_valid && load_ready;
        wr_bad_c = ({1'b0, load_stage} >= IW1'(N_STAGES)) || (load_sel > SEL_A2);
        wr_en_c  = wr_hs_c && !wr_bad_c;
        rd_bad_c = {1'b0, rd_stage} >= IW1'(N_STAGES);
        rd_idx_c = rd_bad_c ? '0 : rd_stage;
    end

    // Next-state logic; COPY walks cnt over every stage then spends one cycle finishing.
    always_comb begin
        next_state = state;
        swap_c     = 1'b0;
        cp_en_c    = 1'b0;
        done_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (commit_req) begin
                    next_state = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (frame_boundary) begin
                    swap_c     = 1'b1;
                    next_state = ST_COPY;
                end
            end
            ST_COPY: begin
                if (cnt < CNT_W'(N_STAGES)) begin
                    cp_en_c = 1'b1;
                end else begin
                    done_c     = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            bank_sel   <= 1'b0;
            cnt        <= '0;
            load_ready <= 1'b1;
            busy       <= 1'b0;
            commit_ack <= 1'b0;
            rd_dvalid  <= 1'b0;
            err_idx    <= 1'b0;
        end else begin
            state      <= next_state;
            load_ready <= (next_state == ST_IDLE);
            busy       <= (next_state != ST_IDLE);
            commit_ack <= done_c;
            rd_dvalid  <= rd_en;
            err_idx    <= (wr_hs_c && wr_bad_c) || (rd_en && rd_bad_c);
            if (swap_c) begin
                bank_sel <= ~bank_sel;
                cnt      <= '0;
            end else if (cp_en_c) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    iir_coeff_ram2 #(
        .COEF_W   (COEF_W),
        .N_STAGES (N_STAGES),
        .IDX_W    (IDX_W)
    ) u_ram (
        .clk      (clk),
        .rst_n    (rst_n),
        .bank_sel (bank_sel),
        .wr_en    (wr_en_c),
        .wr_stage (load_stage),
        .wr_sel   (load_sel),
        .wr_data  (load_data),
        .cp_en    (cp_en_c),
        .cp_stage (IDX_W'(cnt)),
        .rd_en    (rd_en),
        .rd_stage (rd_idx_c),
        .b0       (b0),
        .b1       (b1),
        .b2       (b2),
        .a1       (a1),
        .a2       (a2)
    );

endmodule

// File: tb/tb_iir_coeff_bank.sv
// Directed self-checking bench for iir_coeff_bank with hand-computed expectations.
module tb_iir_coeff_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid;
    logic        load_ready;
    logic [2:0]  load_stage;
    logic [2:0]  load_sel;
    logic [15:0] load_data;
    logic        commit_req;
    logic        frame_boundary;
    logic        commit_ack;
    logic        rd_en;
    logic [2:0]  rd_stage;
    logic [15:0] b0, b1, b2, a1, a2;
    logic        rd_dvalid;
    logic        err_idx;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [79:0] tab [6];

    always #5 clk = ~clk;

    iir_coeff_bank #(.COEF_W(16), .N_STAGES(6), .IDX_W(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_valid     (load_valid),
        .load_ready     (load_ready),
        .load_stage     (load_stage),
        .load_sel       (load_sel),
        .load_data      (load_data),
        .commit_req     (commit_req),
        .frame_boundary (frame_boundary),
        .commit_ack     (commit_ack),
        .rd_en          (rd_en),
        .rd_stage       (rd_stage),
        .b0             (b0),
        .b1             (b1),
        .b2             (b2),
        .a1             (a1),
        .a2             (a2),
        .rd_dvalid      (rd_dvalid),
        .err_idx        (err_idx),
        .busy           (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [2:0] s);
        rd_en    = 1'b1;
        rd_stage = s;
        tick();
        rd_en    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        load_valid = 0; load_stage = 0; load_sel = 0; load_data = 0;
        commit_req = 0; frame_boundary = 0; rd_en = 0; rd_stage = 0;
        #13;
        checks++;
        if ({rd_dvalid, commit_ack, err_idx, busy, load_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_flags got %b want 00001", {rd_dvalid, commit_ack, err_idx, busy, load_ready});
        end
        checks++;
        if ({b0, b1, b2, a1, a2} !== tab[0]) begin
            errors++;
            $display("FAIL reset_coefs got %h want %h", {b0, b1, b2, a1, a2}, tab[0]);
        end
        #4 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_default_table();
        for (int s = 0; s < 6; s++) begin
            do_read(3'(s));
            checks++;
            if (rd_dvalid !== 1'b1 || {b0, b1, b2, a1, a2} !== tab[s]) begin
                errors++;
                $display("FAIL default_stage%0d got v=%b %h want v=1 %h", s, rd_dvalid, {b0, b1, b2, a1, a2}, tab[s]);
            end
        end
        tick();
        checks++;
        if (rd_dvalid !== 1'b0 || {b0, b1, b2, a1, a2} !== tab[5]) begin
            errors++;
            $display("FAIL read_hold got v=%b %h want v=0 %h", rd_dvalid, {b0, b1, b2, a1, a2}, tab[5]);
        end
    endtask

    task automatic test_shadow_write();
        load_valid = 1; load_stage = 3'd2; load_sel = 3'd3; load_data = 16'h1234;
        tick();
        load_valid = 0;
        do_read(3'd2);
        checks++;
        if (a1 !== 16'hE675) begin
            errors++;
            $display("FAIL shadow_isolated a1 got %h want e675", a1);
        end
    endtask

    task automatic test_commit();
        commit_req = 1;
        tick();
        commit_req = 0;
        checks++;
        if (busy !== 1'b1 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL armed busy=%b ready=%b want 1 0", busy, load_ready);
        end
        for (int k = 2; k <= 4; k++) begin
            commit_req = (k == 3);
            tick();
            checks++;
            if (busy !== 1'b1 || commit_ack !== 1'b0) begin
                errors++;
                $display("FAIL armed_wait%0d busy=%b ack=%b want 1 0", k, busy, commit_ack);
            end
        end
        commit_req = 0;
        frame_boundary = 1; rd_en = 1; rd_stage = 3'd2;
        tick();
        frame_boundary = 0;
        checks++;
        if (a1 !== 16'hE675 || busy !== 1'b1) begin
            errors++;
            $display("FAIL swap_edge_read a1=%h busy=%b want e675 1", a1, busy);
        end
        tick();
        rd_en = 0;
        checks++;
        if (a1 !== 16'h1234 || {b0, b1, b2, a2} !== 64'h0FF8_EB7C_0FF8_1C39) begin
            errors++;
            $display("FAIL post_swap_read got %h want 0ff8eb7c0ff812341c39", {b0, b1, b2, a1, a2});
        end
        for (int k = 2; k <= 7; k++) begin
            commit_req = (k == 3);
            tick();
            checks++;
            if (commit_ack !== (k == 7) || busy !== (k != 7)) begin
                errors++;
                $display("FAIL commit_ack_k%0d ack=%b busy=%b want %b %b", k, commit_ack, busy, (k == 7), (k != 7));
            end
        end
        commit_req = 0;
        tick();
        checks++;
        if (commit_ack !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_ack ack=%b busy=%b ready=%b want 0 0 1", commit_ack, busy, load_ready);
        end
    endtask

    task automatic full_commit(input string name);
        commit_req = 1;
        tick();
        commit_req = 0;
        frame_boundary = 1;
        tick();
        frame_boundary = 0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            checks++;
            if (commit_ack !== (k == 7)) begin
                errors++;
                $display("FAIL %s_ack_k%0d got %b want %b", name, k, commit_ack, (k == 7));
            end
        end
    endtask

    task automatic test_back_to_back();
        load_valid = 1; load_stage = 3'd0; load_sel = 3'd1; load_data = 16'h0100;
        commit_req = 1;
        tick();
        load_valid = 0; commit_req = 0;
        frame_boundary = 1;
        tick();
        frame_boundary = 0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            checks++;
            if (commit_ack !== (k == 7)) begin
                errors++;
                $display("FAIL commit2_ack_k%0d got %b want %b", k, commit_ack, (k == 7));
            end
        end
        do_read(3'd0);
        checks++;
        if ({b0, b1, b2, a1, a2} !== 80'h0FF8_0100_0FF8_0B1A_175D) begin
            errors++;
            $display("FAIL commit2_stage0 got %h want 0ff801000ff80b1a175d", {b0, b1, b2, a1, a2});
        end
        do_read(3'd2);
        checks++;
        if (a1 !== 16'h1234) begin
            errors++;
            $display("FAIL copy_preserved a1 got %h want 1234", a1);
        end
    endtask

    task automatic test_bad_index();
        load_valid = 1; load_stage = 3'd7; load_sel = 3'd0; load_data = 16'h5555;
        tick();
        load_valid = 0;
        checks++;
        if (err_idx !== 1'b1) begin
            errors++;
            $display("FAIL err_wr_stage got %b want 1", err_idx);
        end
        tick();
        checks++;
        if (err_idx !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got %b want 0", err_idx);
        end
        load_valid = 1; load_stage = 3'd1; load_sel = 3'd5; load_data = 16'h5555;
        tick();
        load_valid = 0;
        checks++;
        if (err_idx !== 1'b1) begin
            errors++;
            $display("FAIL err_wr_sel got %b want 1", err_idx);
        end
        do_read(3'd6);
        checks++;
        if (err_idx !== 1'b1 || rd_dvalid !== 1'b1 || {b0, b1, b2, a1, a2} !== 80'h0FF8_0100_0FF8_0B1A_175D) begin
            errors++;
            $display("FAIL err_rd err=%b v=%b got %h want 1 1 0ff801000ff80b1a175d", err_idx, rd_dvalid, {b0, b1, b2, a1, a2});
        end
        frame_boundary = 1;
        tick();
        frame_boundary = 0;
        checks++;
        if (busy !== 1'b0 || err_idx !== 1'b0) begin
            errors++;
            $display("FAIL fb_idle busy=%b err=%b want 0 0", busy, err_idx);
        end
        full_commit("commit3");
        do_read(3'd0);
        checks++;
        if ({b0, b1, b2, a1, a2} !== 80'h0FF8_0100_0FF8_0B1A_175D) begin
            errors++;
            $display("FAIL bad_wr_stage0 got %h want 0ff801000ff80b1a175d", {b0, b1, b2, a1, a2});
        end
        do_read(3'd1);
        checks++;
        if ({b0, b1, b2, a1, a2} !== tab[1]) begin
            errors++;
            $display("FAIL bad_wr_stage1 got %h want %h", {b0, b1, b2, a1, a2}, tab[1]);
        end
    endtask

    task automatic test_reset_in_copy();
        load_valid = 1; load_stage = 3'd2; load_sel = 3'd3; load_data = 16'h7777;
        tick();
        load_valid = 0;
        commit_req = 1;
        tick();
        commit_req = 0;
        frame_boundary = 1; rd_en = 1; rd_stage = 3'd1;
        tick();
        frame_boundary = 0; rd_en = 0;
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL in_copy busy got %b want 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rd_dvalid, commit_ack, err_idx, busy, load_ready} !== 5'b00001 || {b0, b1, b2, a1, a2} !== tab[0]) begin
            errors++;
            $display("FAIL copy_reset flags=%b coefs=%h want 00001 %h", {rd_dvalid, commit_ack, err_idx, busy, load_ready}, {b0, b1, b2, a1, a2}, tab[0]);
        end
        #1 rst_n = 1'b1;
        tick();
        do_read(3'd2);
        checks++;
        if (a1 !== 16'hE675) begin
            errors++;
            $display("FAIL copy_reset_a1 got %h want e675", a1);
        end
        do_read(3'd0);
        checks++;
        if (b1 !== 16'h1C9D) begin
            errors++;
            $display("FAIL copy_reset_b1 got %h want 1c9d", b1);
        end
    endtask

    initial begin
        tab[0] = 80'h0FF8_1C9D_0FF8_0B1A_175D;
        tab[1] = 80'h0FF8_E363_0FF8_F4E6_175D;
        tab[2] = 80'h0FF8_EB7C_0FF8_E675_1C39;
        tab[3] = 80'h0FF8_1484_0FF8_198B_1C39;
        tab[4] = 80'h0FF8_120F_0FF8_1ED8_1F1B;
        tab[5] = 80'h0FF8_EDF1_0FF8_E128_1F1B;
        test_reset();
        test_default_table();
        test_shadow_write();
        test_commit();
        test_back_to_back();
        test_bad_index();
        test_reset_in_copy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
